// File: rtl/spi_temp_filter.sv
// spi_temp_filter: averages 2**AVG_LOG2 SPI temperature samples and outputs C or F (2 fractional bits).
// Define SPI_TEMP_ROUND_EN for round-half-up averaging and F conversion instead of floor.
module spi_temp_filter #(
  parameter int DATA_W   = 10,
  parameter int SPI_MSB  = 14,
  parameter int AVG_LOG2 = 2,
  parameter int INT_W    = 7
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_use_f,
  input  logic               i_spi_valid,
  input  logic [15:0]        i_spi_data,
  output logic               o_ready,
  output logic               o_temp_valid,
  output logic [INT_W+1:0]   o_temp_data,
  output logic               o_sat
);
`ifdef SPI_TEMP_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif
  localparam int AW   = DATA_W + AVG_LOG2;
  localparam int CW   = AVG_LOG2 + 1;
  localparam int N    = DATA_W + 4;
  localparam int OW   = INT_W + 2;
  localparam int DCW  = $clog2(N);
  localparam int HALF = R * ((1 << AVG_LOG2) >> 1);
  typedef enum logic [1:0] {ACC, AVG, DIV, OUT} state_t;
  state_t state, next;
  logic [AW-1:0] acc;
  logic [AW+R-1:0] sum;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] q, q_n;
  logic [N-1:0] div, dvd;
  logic [2:0] rem, rem_n;
  logic [3:0] t;
  logic [DCW-1:0] dcnt;
  logic [N:0] res;
  logic f, take, last, ge, sat;
  logic unused_bits;
  assign unused_bits = ^i_spi_data;
  always_comb begin
    take  = i_spi_valid & o_ready;
    last  = cnt == CW'((1 << AVG_LOG2) - 1);
    sum   = (AW+R)'(acc) + (AW+R)'(HALF);
    q_n   = DATA_W'(sum >> AVG_LOG2);
    dvd   = (N'(q_n) << 3) + N'(q_n) + N'(2 * R);
    t     = {rem, div[N-1]};
    ge    = t >= 4'd5;
    rem_n = ge ? 3'(t - 4'd5) : t[2:0];
    res   = f ? (N+1)'(div) + (N+1)'(128) : (N+1)'(q);
    sat   = res > (N+1)'((1 << OW) - 1);
    next  = state;
    case (state)
      ACC: next = take && last ? AVG : ACC;
      AVG: next = i_use_f ? DIV : OUT;
      DIV: next = dcnt == DCW'(N - 1) ? OUT : DIV;
      OUT: next = ACC;
      default: next = ACC;
    endcase
  end
  always_ff @(posedge i_clk)
    state <= !i_resetn ? ACC : next;
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      acc          <= '0;
      cnt          <= '0;
      q            <= '0;
      f            <= 1'b0;
      div          <= '0;
      rem          <= '0;
      dcnt         <= '0;
      o_ready      <= 1'b0;
      o_temp_valid <= 1'b0;
      o_temp_data  <= '0;
      o_sat        <= 1'b0;
    end else begin
      o_ready      <= next == ACC;
      o_temp_valid <= state == OUT;
      if (state == ACC && take) begin
        acc <= acc + AW'(i_spi_data[SPI_MSB -: DATA_W]);
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (state == AVG) begin
        q    <= q_n;
        f    <= i_use_f;
        div  <= dvd;
        rem  <= '0;
        dcnt <= '0;
        acc  <= '0;
      end
      if (state == DIV) begin
        div  <= {div[N-2:0], ge};
        rem  <= rem_n;
        dcnt <= dcnt + 1'b1;
      end
      if (state == OUT) begin
        o_temp_data <= sat ? '1 : OW'(res);
        o_sat       <= sat;
      end
    end
  end
endmodule
